wb_sdram_port: RTL and testbench

WB_SDRAM_PORT -- requirements
Module: wb_sdram_port

---
 rtl/wb_sdram_port.sv | 195 +++++++++++++++++++
 tb/tb_wb_sdram_port.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_sdram_port.sv
// Wishbone-to-SDRAM bridge with a one-line (16-byte) write-through read cache.
// Read hit: ack one cycle after the request. Miss: 8-halfword burst fill. Writes: one controller write per selected halfword.
module wb_sdram_port (
    input  logic        sdram_clk,
    input  logic        sdram_rst,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic [31:0] sdram_adr_o,
    output logic [15:0] sdram_dat_o,
    output logic [1:0]  sdram_sel_o,
    output logic        sdram_we_o,
    output logic        sdram_acc_o,
    input  logic        sdram_ack_i,
    input  logic [31:0] sdram_adr_i,
    input  logic [15:0] sdram_dat_i,
    input  logic        sdram_idle_i
);

    typedef enum logic [2:0] {IDLE, WR_HI, WR_LO, RD_REQ, RD_FILL, ACK} state_t;

    state_t      state_q;
    logic [15:0] buf_q [8];
    logic [15:0] buf_d [8];
    logic [27:0] tag_q;
    logic        valid_q;
    logic [2:0]  cnt_q;
    logic        req_q;
    logic        we_q;
    logic [31:0] adr_q;
    logic [15:0] dat_q;
    logic [1:0]  sel_q;
    logic        wb_ack_q;
    logic [31:0] wb_dat_q;
    logic        abort_q;
    logic [31:2] lat_adr_q;
    logic [15:0] lat_dat_q;
    logic [1:0]  lat_sel_q;

    logic        new_req;
    logic        hit;
    logic [2:0]  hi_idx;
    logic [2:0]  lo_idx;
    logic [2:0]  rd_hi_idx;
    logic [2:0]  rd_lo_idx;
    logic        unused_ok;

    assign new_req   = wb_cyc_i & wb_stb_i;
    assign hit       = valid_q && (tag_q == wb_adr_i[31:4]);
    assign hi_idx    = {wb_adr_i[3:2], 1'b0};
    assign lo_idx    = {wb_adr_i[3:2], 1'b1};
    assign rd_hi_idx = {lat_adr_q[3:2], 1'b0};
    assign rd_lo_idx = {lat_adr_q[3:2], 1'b1};
    assign unused_ok = &{1'b0, sdram_idle_i, sdram_adr_i[31:4], sdram_adr_i[0], wb_adr_i[1:0]};

    // Fill data lands at the controller-reported address, so wrap-around bursts fill correctly.
    always_comb begin
        buf_d = buf_q;
        if ((state_q == RD_REQ && sdram_ack_i) || state_q == RD_FILL) begin
            buf_d[sdram_adr_i[3:1]] = sdram_dat_i;
        end else if (state_q == IDLE && new_req && wb_we_i && hit) begin
            if (wb_sel_i[3]) buf_d[hi_idx][15:8] = wb_dat_i[31:24];
            if (wb_sel_i[2]) buf_d[hi_idx][7:0]  = wb_dat_i[23:16];
            if (wb_sel_i[1]) buf_d[lo_idx][15:8] = wb_dat_i[15:8];
            if (wb_sel_i[0]) buf_d[lo_idx][7:0]  = wb_dat_i[7:0];
        end
    end

    always_ff @(posedge sdram_clk) begin
        buf_q <= buf_d;
    end

    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            state_q   <= IDLE;
            tag_q     <= '0;
            valid_q   <= 1'b0;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            wb_ack_q  <= 1'b0;
            wb_dat_q  <= '0;
            abort_q   <= 1'b0;
            lat_adr_q <= '0;
            lat_dat_q <= '0;
            lat_sel_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    abort_q <= 1'b0;
                    if (new_req) begin
                        lat_adr_q <= wb_adr_i[31:2];
                        lat_dat_q <= wb_dat_i[15:0];
                        lat_sel_q <= wb_sel_i[1:0];
                        if (!wb_we_i) begin
                            if (hit) begin
                                wb_dat_q <= {buf_q[hi_idx], buf_q[lo_idx]};
                                wb_ack_q <= 1'b1;
                                state_q  <= ACK;
                            end else begin
                                valid_q <= 1'b0;
                                req_q   <= 1'b1;
                                we_q    <= 1'b0;
                                adr_q   <= {wb_adr_i[31:2], 2'b00};
                                state_q <= RD_REQ;
                            end
                        end else if (|wb_sel_i[3:2]) begin
                            req_q   <= 1'b1;
                            we_q    <= 1'b1;
                            adr_q   <= {wb_adr_i[31:2], 2'b00};
                            dat_q   <= wb_dat_i[31:16];
                            sel_q   <= wb_sel_i[3:2];
                            state_q <= WR_HI;
                        end else if (|wb_sel_i[1:0]) begin
                            req_q   <= 1'b1;
                            we_q    <= 1'b1;
                            adr_q   <= {wb_adr_i[31:2], 2'b10};
                            dat_q   <= wb_dat_i[15:0];
                            sel_q   <= wb_sel_i[1:0];
                            state_q <= WR_LO;
                        end else begin
                            wb_ack_q <= 1'b1;
                            state_q  <= ACK;
                        end
                    end
                end
                WR_HI: begin
                    if (sdram_ack_i) begin
                        if (|lat_sel_q) begin
                            adr_q   <= {lat_adr_q, 2'b10};
                            dat_q   <= lat_dat_q;
                            sel_q   <= lat_sel_q;
                            state_q <= WR_LO;
                        end else begin
                            req_q    <= 1'b0;
                            we_q     <= 1'b0;
                            wb_ack_q <= wb_cyc_i & ~abort_q;
                            state_q  <= ACK;
                        end
                    end
                end
                WR_LO: begin
                    if (sdram_ack_i) begin
                        req_q    <= 1'b0;
                        we_q     <= 1'b0;
                        wb_ack_q <= wb_cyc_i & ~abort_q;
                        state_q  <= ACK;
                    end
                end
                RD_REQ: begin
                    if (sdram_ack_i) begin
                        req_q   <= 1'b0;
                        cnt_q   <= 3'd1;
                        state_q <= RD_FILL;
                    end
                end
                RD_FILL: begin
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        tag_q    <= lat_adr_q[31:4];
                        valid_q  <= 1'b1;
                        cnt_q    <= '0;
                        wb_dat_q <= {buf_d[rd_hi_idx], buf_d[rd_lo_idx]};
                        wb_ack_q <= wb_cyc_i & ~abort_q;
                        state_q  <= ACK;
                    end
                end
                ACK: begin
                    wb_ack_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            // A master that abandons the cycle still lets the access finish, but gets no ack.
            if (state_q != IDLE && !wb_cyc_i) abort_q <= 1'b1;
        end
    end

    assign wb_ack_o    = wb_ack_q;
    assign wb_dat_o    = wb_dat_q;
    assign sdram_adr_o = adr_q;
    assign sdram_dat_o = dat_q;
    assign sdram_sel_o = sel_q;
    assign sdram_we_o  = we_q;
    assign sdram_acc_o = req_q & ~sdram_ack_i;

endmodule

// File: tb/tb_wb_sdram_port.sv
// Bench for wb_sdram_port: SDRAM controller model with a halfword memory, plus a cache-level reference.
module tb_wb_sdram_port;

    logic        sdram_clk = 1'b0;
    logic        sdram_rst;
    logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o;
    logic [31:0] sdram_adr_o, sdram_adr_i;
    logic [15:0] sdram_dat_o, sdram_dat_i;
    logic [1:0]  sdram_sel_o;
    logic        sdram_we_o, sdram_acc_o, sdram_ack_i, sdram_idle_i;

    wb_sdram_port dut (
        .sdram_clk(sdram_clk), .sdram_rst(sdram_rst),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .sdram_adr_o(sdram_adr_o), .sdram_dat_o(sdram_dat_o), .sdram_sel_o(sdram_sel_o),
        .sdram_we_o(sdram_we_o), .sdram_acc_o(sdram_acc_o), .sdram_ack_i(sdram_ack_i),
        .sdram_adr_i(sdram_adr_i), .sdram_dat_i(sdram_dat_i), .sdram_idle_i(sdram_idle_i)
    );

    always #5 sdram_clk = ~sdram_clk;

    typedef struct packed {
        logic [31:0] adr;
        logic [15:0] dat;
        logic [1:0]  sel;
    } wr_t;

    int          tot = 0;
    int          bad = 0;
    int          rd_cnt = 0;
    int          ack_total = 0;
    logic [31:0] rd_last = '0;
    wr_t         wr_log[$];
    logic [15:0] mem [logic [30:0]];
    logic        m_valid = 1'b0;
    logic [27:0] m_tag = '0;

    function automatic logic [15:0] mem_rd(input logic [31:0] a);
        int i;
        if (mem.exists(a[31:1])) return mem[a[31:1]];
        i = int'(a[3:1]);
        if (a[31:4] == 28'h10) return 16'((i + 1) * 32'h1111);
        return a[15:0] ^ a[31:16] ^ 16'hA5C3;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {mem_rd({a[31:2], 2'b00}), mem_rd({a[31:2], 2'b10})};
    endfunction

    always @(negedge sdram_clk) if (wb_ack_o === 1'b1) ack_total++;

    // Controller model: accepts a request, random latency, then one write ack or an 8-halfword wrapping burst.
    always begin : ctrl_model
        logic [31:0] ca;
        logic        cw;
        logic [15:0] cd, old;
        logic [1:0]  cs;
        logic [2:0]  ci;
        wr_t         e;
        @(negedge sdram_clk);
        if (!sdram_rst && sdram_acc_o === 1'b1) begin
            ca = sdram_adr_o; cw = sdram_we_o; cd = sdram_dat_o; cs = sdram_sel_o;
            repeat ($urandom_range(0, 2)) @(negedge sdram_clk);
            if (cw) begin
                e.adr = ca; e.dat = cd; e.sel = cs;
                wr_log.push_back(e);
                old = mem_rd(ca);
                if (cs[1]) old[15:8] = cd[15:8];
                if (cs[0]) old[7:0]  = cd[7:0];
                mem[ca[31:1]] = old;
                sdram_adr_i = ca;
                sdram_dat_i = 16'($urandom);
                sdram_ack_i = 1'b1;
                @(negedge sdram_clk);
                sdram_ack_i = 1'b0;
            end else begin
                rd_cnt++;
                rd_last = ca;
                for (int k = 0; k < 8; k++) begin
                    if (sdram_rst) break;
                    ci = ca[3:1] + 3'(k);
                    sdram_adr_i = {ca[31:4], ci, 1'b0};
                    sdram_dat_i = mem_rd(sdram_adr_i);
                    sdram_ack_i = 1'b1;
                    @(negedge sdram_clk);
                end
                sdram_ack_i = 1'b0;
            end
        end
    end

    task automatic wb_xfer(input logic [31:0] a, input logic we, input logic [31:0] d, input logic [3:0] s,
                           output logic [31:0] rd, output int lat, output logic ok);
        wb_adr_i = a; wb_we_i = we; wb_dat_i = d; wb_sel_i = s; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        lat = 0; ok = 1'b0;
        while (!ok && lat < 200) begin
            @(negedge sdram_clk);
            lat++;
            ok = (wb_ack_o === 1'b1);
        end
        rd = wb_dat_o;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        @(negedge sdram_clk);
    endtask

    task automatic test_reset();
        #2;
        tot++;
        if ({wb_ack_o, wb_dat_o, sdram_acc_o, sdram_we_o, sdram_adr_o, sdram_dat_o, sdram_sel_o} !== '0) begin
            bad++; $display("FAIL reset_async got ack=%b dat=%h acc=%b we=%b adr=%h sdat=%h sel=%b want all 0",
                            wb_ack_o, wb_dat_o, sdram_acc_o, sdram_we_o, sdram_adr_o, sdram_dat_o, sdram_sel_o);
        end
        repeat (3) @(negedge sdram_clk);
        tot++;
        if ({wb_ack_o, wb_dat_o, sdram_acc_o, sdram_we_o, sdram_adr_o, sdram_dat_o, sdram_sel_o} !== '0) begin
            bad++; $display("FAIL reset_clocked got ack=%b acc=%b adr=%h want 0", wb_ack_o, sdram_acc_o, sdram_adr_o);
        end
        sdram_rst = 1'b0;
        m_valid = 1'b0;
        @(negedge sdram_clk);
    endtask

    task automatic test_read_miss();
        logic [31:0] rd; int lat; logic ok; int r0, a0;
        r0 = rd_cnt; a0 = ack_total;
        wb_xfer(32'h0000_0104, 1'b0, 32'h0, 4'hF, rd, lat, ok);
        tot++; if (ok !== 1'b1) begin bad++; $display("FAIL miss_ack got=%b want=1", ok); end
        tot++; if (rd !== 32'h3333_4444) begin bad++; $display("FAIL miss_data got=%h want=33334444", rd); end
        tot++; if (rd_cnt - r0 !== 1) begin bad++; $display("FAIL miss_bursts got=%0d want=1", rd_cnt - r0); end
        tot++; if (rd_last !== 32'h104) begin bad++; $display("FAIL miss_adr got=%h want=00000104", rd_last); end
        tot++; if (ack_total - a0 !== 1) begin bad++; $display("FAIL miss_ack_count got=%0d want=1", ack_total - a0); end
        m_valid = 1'b1; m_tag = 28'h10;
    endtask

    task automatic test_read_hit();
        logic [31:0] rd; int lat; logic ok; int r0;
        r0 = rd_cnt;
        wb_xfer(32'h0000_010C, 1'b0, 32'h0, 4'hF, rd, lat, ok);
        tot++; if (rd !== 32'h7777_8888) begin bad++; $display("FAIL hit_data got=%h want=77778888", rd); end
        tot++; if (lat !== 1) begin bad++; $display("FAIL hit_latency got=%0d want=1", lat); end
        tot++; if (rd_cnt !== r0) begin bad++; $display("FAIL hit_no_burst got=%0d want=0", rd_cnt - r0); end
        tot++; if (wb_ack_o !== 1'b0) begin bad++; $display("FAIL hit_ack_width got=%b want=0", wb_ack_o); end
    endtask

    task automatic test_write();
        logic [31:0] rd; int lat; logic ok; int r0, w0; wr_t exp;
        w0 = wr_log.size(); r0 = rd_cnt;
        wb_xfer(32'h0000_0108, 1'b1, 32'hAABB_CCDD, 4'b1100, rd, lat, ok);
        exp.adr = 32'h108; exp.dat = 16'hAABB; exp.sel = 2'b11;
        tot++; if (ok !== 1'b1) begin bad++; $display("FAIL wr_ack got=%b want=1", ok); end
        tot++; if (wr_log.size() - w0 !== 1) begin bad++; $display("FAIL wr_count got=%0d want=1", wr_log.size() - w0); end
        else begin
            tot++; if (wr_log[w0] !== exp) begin bad++; $display("FAIL wr_entry got=%h want=%h", wr_log[w0], exp); end
        end
        wb_xfer(32'h0000_0108, 1'b0, 32'h0, 4'hF, rd, lat, ok);
        tot++; if (rd !== 32'hAABB_6666) begin bad++; $display("FAIL wr_readback got=%h want=aabb6666", rd); end
        tot++; if (lat !== 1 || rd_cnt !== r0) begin bad++; $display("FAIL wr_readback_hit got lat=%0d bursts=%0d want 1/0", lat, rd_cnt - r0); end
    endtask

    task automatic test_write_sel();
        logic [31:0] rd, d; int lat; logic ok; int w0, r0; wr_t e0, e1;
        d = $urandom; w0 = wr_log.size(); r0 = rd_cnt;
        wb_xfer(32'h0000_0100, 1'b1, d, 4'b1111, rd, lat, ok);
        e0.adr = 32'h100; e0.dat = d[31:16]; e0.sel = 2'b11;
        e1.adr = 32'h102; e1.dat = d[15:0];  e1.sel = 2'b11;
        tot++; if (wr_log.size() - w0 !== 2) begin bad++; $display("FAIL wr2_count got=%0d want=2", wr_log.size() - w0); end
        else begin
            tot++; if (wr_log[w0] !== e0 || wr_log[w0+1] !== e1) begin
                bad++; $display("FAIL wr2_order got=%h,%h want=%h,%h", wr_log[w0], wr_log[w0+1], e0, e1);
            end
        end
        w0 = wr_log.size();
        wb_xfer(32'h0000_0100, 1'b1, 32'hDEAD_BEEF, 4'b0000, rd, lat, ok);
        tot++; if (ok !== 1'b1) begin bad++; $display("FAIL wr0_ack got=%b want=1", ok); end
        tot++; if (wr_log.size() !== w0) begin bad++; $display("FAIL wr0_count got=%0d want=0", wr_log.size() - w0); end
        wb_xfer(32'h0000_0100, 1'b0, 32'h0, 4'hF, rd, lat, ok);
        tot++; if (rd !== d || rd_cnt !== r0) begin bad++; $display("FAIL wr2_readback got=%h bursts=%0d want=%h/0", rd, rd_cnt - r0, d); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] pat;
        wb_adr_i = 32'h0000_010C; wb_we_i = 1'b0; wb_sel_i = 4'hF; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            @(negedge sdram_clk);
            pat[i] = wb_ack_o;
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(negedge sdram_clk);
        tot++; if (pat !== 4'b1010) begin bad++; $display("FAIL held_stb_acks got=%b want=1010", pat); end
    endtask

    task automatic test_cyc_drop();
        logic [31:0] rd; int lat; logic ok; int r0, a0, n;
        r0 = rd_cnt; a0 = ack_total; n = 0;
        wb_adr_i = 32'h0000_0208; wb_we_i = 1'b0; wb_sel_i = 4'hF; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        while (rd_cnt == r0 && n < 50) begin @(negedge sdram_clk); n++; end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        repeat (30) @(negedge sdram_clk);
        tot++; if (ack_total !== a0) begin bad++; $display("FAIL drop_no_ack got=%0d want=0", ack_total - a0); end
        tot++; if (rd_cnt - r0 !== 1) begin bad++; $display("FAIL drop_burst got=%0d want=1", rd_cnt - r0); end
        m_valid = 1'b1; m_tag = 28'h20;
        wb_xfer(32'h0000_0208, 1'b0, 32'h0, 4'hF, rd, lat, ok);
        tot++; if (lat !== 1 || rd_cnt - r0 !== 1) begin bad++; $display("FAIL drop_valid got lat=%0d bursts=%0d want 1/1", lat, rd_cnt - r0); end
        tot++; if (rd !== mem_word(32'h208)) begin bad++; $display("FAIL drop_data got=%h want=%h", rd, mem_word(32'h208)); end
    endtask

    task automatic test_reset_mid_fill();
        logic [31:0] rd; int lat; logic ok; int r0, a0, n;
        r0 = rd_cnt; n = 0;
        wb_adr_i = 32'h0000_0304; wb_we_i = 1'b0; wb_sel_i = 4'hF; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        do begin @(negedge sdram_clk); #1; n++; end while (sdram_ack_i !== 1'b1 && n < 60);
        tot++; if (sdram_ack_i !== 1'b1) begin bad++; $display("FAIL rstfill_start got=%b want=1", sdram_ack_i); end
        repeat (2) @(negedge sdram_clk);
        #2 sdram_rst = 1'b1; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        #1;
        tot++;
        if ({wb_ack_o, wb_dat_o, sdram_acc_o, sdram_we_o, sdram_adr_o, sdram_dat_o, sdram_sel_o} !== '0) begin
            bad++; $display("FAIL rstfill_outputs got ack=%b dat=%h acc=%b adr=%h want all 0", wb_ack_o, wb_dat_o, sdram_acc_o, sdram_adr_o);
        end
        repeat (2) @(negedge sdram_clk);
        sdram_rst = 1'b0; m_valid = 1'b0;
        a0 = ack_total;
        repeat (15) @(negedge sdram_clk);
        tot++; if (ack_total !== a0) begin bad++; $display("FAIL rstfill_no_ack got=%0d want=0", ack_total - a0); end
        r0 = rd_cnt;
        wb_xfer(32'h0000_0304, 1'b0, 32'h0, 4'hF, rd, lat, ok);
        tot++; if (rd_cnt - r0 !== 1) begin bad++; $display("FAIL rstfill_refill got=%0d want=1", rd_cnt - r0); end
        tot++; if (rd !== mem_word(32'h304) || ok !== 1'b1) begin bad++; $display("FAIL rstfill_data got=%h want=%h", rd, mem_word(32'h304)); end
        m_valid = 1'b1; m_tag = 28'h30;
    endtask

    task automatic test_random();
        logic [31:0] lines [4];
        logic [31:0] a, d, rd, exp_rd;
        logic [3:0]  s;
        logic        we, ok, miss;
        int          lat, r0, w0, a0;
        wr_t         e;
        wr_t         exp_q[$];
        lines = '{32'h0000_0100, 32'h0000_0200, 32'h0000_0FF0, 32'hFFFF_FFF0};
        for (int op = 0; op < 40; op++) begin
            a  = lines[$urandom_range(0, 3)] | (32'($urandom_range(0, 3)) << 2);
            we = 1'($urandom_range(0, 1));
            d  = $urandom;
            s  = 4'($urandom_range(0, 15));
            r0 = rd_cnt; w0 = wr_log.size(); a0 = ack_total;
            exp_q.delete();
            miss = !(m_valid && m_tag == a[31:4]);
            exp_rd = mem_word(a);
            if (we) begin
                if (s[3:2] != 2'b00) begin e.adr = {a[31:2], 2'b00}; e.dat = d[31:16]; e.sel = s[3:2]; exp_q.push_back(e); end
                if (s[1:0] != 2'b00) begin e.adr = {a[31:2], 2'b10}; e.dat = d[15:0];  e.sel = s[1:0]; exp_q.push_back(e); end
            end
            wb_xfer(a, we, d, s, rd, lat, ok);
            tot++; if (ok !== 1'b1 || ack_total - a0 !== 1) begin bad++; $display("FAIL rnd_ack op=%0d got ok=%b acks=%0d want 1/1", op, ok, ack_total - a0); end
            if (we) begin
                tot++;
                if (wr_log.size() - w0 !== exp_q.size() || rd_cnt !== r0) begin
                    bad++; $display("FAIL rnd_wr_count op=%0d got=%0d want=%0d", op, wr_log.size() - w0, exp_q.size());
                end else begin
                    for (int j = 0; j < exp_q.size(); j++) begin
                        tot++;
                        if (wr_log[w0+j] !== exp_q[j]) begin bad++; $display("FAIL rnd_wr op=%0d got=%h want=%h", op, wr_log[w0+j], exp_q[j]); end
                    end
                end
            end else begin
                tot++; if (rd !== exp_rd) begin bad++; $display("FAIL rnd_rd op=%0d adr=%h got=%h want=%h", op, a, rd, exp_rd); end
                tot++; if (rd_cnt - r0 !== int'(miss)) begin bad++; $display("FAIL rnd_miss op=%0d got=%0d want=%0d", op, rd_cnt - r0, miss); end
                m_valid = 1'b1; m_tag = a[31:4];
            end
        end
    endtask

    initial begin
        sdram_rst = 1'b1;
        wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; wb_we_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        sdram_ack_i = 1'b0; sdram_adr_i = '0; sdram_dat_i = '0; sdram_idle_i = 1'b1;
        test_reset();
        test_read_miss();
        test_read_hit();
        test_write();
        test_write_sel();
        test_back_to_back();
        test_cyc_drop();
        test_reset_mid_fill();
        test_random();
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
